// File: rtl/h_pfn_pkg.sv
// Shared types for the hot-PFN drain path: FSM states and PFN entry type.
package h_pfn_pkg;
    localparam int PFN_ENTRY_WIDTH = 32;
    localparam int PFN_NUM_ENTRIES = 1024;

    typedef logic [PFN_ENTRY_WIDTH-1:0] pfn_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WAIT = 2'd2,
        RST  = 2'd3
    } drain_state_e;
endpackage

// File: rtl/h_pfn_skid_fifo.sv
// 2-entry FIFO catching buffer read returns; the producer keeps it from overflowing via the count output.
module h_pfn_skid_fifo
    import h_pfn_pkg::*;
#(
    parameter int WIDTH = PFN_ENTRY_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       count
);
    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             pop;

    assign out_valid = count != 2'd0;
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (in_valid) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, in_valid} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/h_pfn_drain_ctrl.sv
// Drain sequencer for the hot-PFN buffer: streams entries 0..end_idx-1 out, then resets the write index.
// Optional PFN_DRAIN_DEDUP_EN suppresses back-to-back repeated PFNs and adds dedup_cnt.
module h_pfn_drain_ctrl
    import h_pfn_pkg::*;
#(
    parameter int NUM_ENTRIES = PFN_NUM_ENTRIES,
    parameter int ENTRY_WIDTH = PFN_ENTRY_WIDTH,
    parameter int NUM_IDX_BIT = $clog2(NUM_ENTRIES),
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   drain_start,
    input  logic [NUM_IDX_BIT-1:0] drain_thresh,
    input  logic                   trk_wr_en,
    output logic                   trk_wr_ready,
    output logic                   buf_wr_en,
    input  logic [NUM_IDX_BIT-1:0] buf_wr_idx,
    input  logic                   buf_wr_overflow,
    output logic                   buf_wr_idx_rst,
    output logic                   buf_rd_en,
    output logic [NUM_IDX_BIT-1:0] buf_rd_idx,
    input  logic [ENTRY_WIDTH-1:0] buf_rd_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ENTRY_WIDTH-1:0] out_pfn,
    output logic                   busy,
    output logic                   drain_done,
    output logic [CNT_WIDTH-1:0]   drained_cnt,
    output logic                   ovf_sticky
`ifdef PFN_DRAIN_DEDUP_EN
    ,
    output logic [CNT_WIDTH-1:0]   dedup_cnt
`endif
);
    drain_state_e           state, state_nxt;
    logic [NUM_IDX_BIT-1:0] end_idx, end_idx_nxt;
    logic [NUM_IDX_BIT-1:0] rd_ptr, rd_ptr_nxt;
    logic                   rd_inflight;
    logic [1:0]             fifo_cnt;
    logic                   fifo_valid;
    logic                   fifo_pop;
    logic [ENTRY_WIDTH-1:0] fifo_head;
    logic                   thresh_hit;
    logic                   credit;

    assign thresh_hit = (drain_thresh != '0) && (buf_wr_idx >= drain_thresh);
    // Read-return slots: never more than two reads between issue and pop.
    assign credit     = (fifo_cnt + {1'b0, rd_inflight}) < 2'd2;
    assign buf_rd_idx = rd_ptr;
    assign buf_wr_en  = trk_wr_en & trk_wr_ready;
    assign busy       = state != IDLE;

    always_comb begin
        state_nxt      = state;
        end_idx_nxt    = end_idx;
        rd_ptr_nxt     = rd_ptr;
        buf_rd_en      = 1'b0;
        trk_wr_ready   = 1'b1;
        buf_wr_idx_rst = 1'b0;
        drain_done     = 1'b0;
        case (state)
            IDLE: if ((drain_start || thresh_hit) && buf_wr_idx != '0) begin
                state_nxt   = READ;
                end_idx_nxt = buf_wr_idx;
                rd_ptr_nxt  = '0;
            end
            READ: if (rd_ptr == end_idx) begin
                state_nxt = WAIT;
            end else if (credit) begin
                buf_rd_en  = 1'b1;
                rd_ptr_nxt = rd_ptr + NUM_IDX_BIT'(1);
            end
            WAIT: if (fifo_cnt == 2'd0 && !rd_inflight) begin
                if (buf_wr_idx != end_idx) begin
                    end_idx_nxt = buf_wr_idx;
                    state_nxt   = READ;
                end else begin
                    state_nxt = RST;
                end
            end
            RST: begin
                // Writes are blocked here so the index reset cannot drop one; a write
                // that slipped in during WAIT shows up as a moved index and is drained first.
                trk_wr_ready = 1'b0;
                if (buf_wr_idx == end_idx) begin
                    buf_wr_idx_rst = reset_n;
                    drain_done     = reset_n;
                    state_nxt      = IDLE;
                end else begin
                    end_idx_nxt = buf_wr_idx;
                    state_nxt   = READ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            end_idx     <= '0;
            rd_ptr      <= '0;
            rd_inflight <= 1'b0;
            drained_cnt <= '0;
            ovf_sticky  <= 1'b0;
        end else begin
            state       <= state_nxt;
            end_idx     <= end_idx_nxt;
            rd_ptr      <= rd_ptr_nxt;
            rd_inflight <= buf_rd_en;
            if (out_valid && out_ready) drained_cnt <= drained_cnt + CNT_WIDTH'(1);
            if (buf_wr_overflow) ovf_sticky <= 1'b1;
        end
    end

    h_pfn_skid_fifo #(.WIDTH(ENTRY_WIDTH)) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (rd_inflight),
        .in_data   (buf_rd_data),
        .out_valid (fifo_valid),
        .out_data  (fifo_head),
        .out_ready (fifo_pop),
        .count     (fifo_cnt)
    );

    assign out_pfn = fifo_head;

`ifdef PFN_DRAIN_DEDUP_EN
    logic [ENTRY_WIDTH-1:0] last_pfn;
    logic                   last_vld;
    logic                   dup;

    assign dup       = fifo_valid && last_vld && (fifo_head == last_pfn);
    assign out_valid = fifo_valid && !dup;
    assign fifo_pop  = dup || (out_valid && out_ready);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_vld  <= 1'b0;
            last_pfn  <= '0;
            dedup_cnt <= '0;
        end else begin
            if (state == IDLE && state_nxt == READ) begin
                last_vld <= 1'b0;
            end else if (out_valid && out_ready) begin
                last_vld <= 1'b1;
                last_pfn <= out_pfn;
            end
            if (dup) dedup_cnt <= dedup_cnt + CNT_WIDTH'(1);
        end
    end
`else
    assign out_valid = fifo_valid;
    assign fifo_pop  = out_valid && out_ready;
`endif
endmodule

// File: tb/tb_h_pfn_drain_ctrl.sv
// Bench for h_pfn_drain_ctrl: behavioural buffer plus a scoreboard of captured PFNs in write order.
module tb_h_pfn_drain_ctrl;
    import h_pfn_pkg::*;
    localparam int IW = 10;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          drain_start = 1'b0;
    logic [IW-1:0] drain_thresh = '0;
    logic          trk_wr_en = 1'b0;
    logic          trk_wr_ready, buf_wr_en, buf_wr_overflow, buf_wr_idx_rst, buf_rd_en;
    logic [IW-1:0] buf_wr_idx, buf_rd_idx;
    logic [31:0]   buf_rd_data, out_pfn, drained_cnt;
    logic          out_valid, busy, drain_done, ovf_sticky;
    logic          out_ready = 1'b1;
`ifdef PFN_DRAIN_DEDUP_EN
    logic [31:0]   dedup_cnt;
`endif

    h_pfn_drain_ctrl dut (
        .clk(clk), .reset_n(reset_n), .drain_start(drain_start), .drain_thresh(drain_thresh),
        .trk_wr_en(trk_wr_en), .trk_wr_ready(trk_wr_ready), .buf_wr_en(buf_wr_en),
        .buf_wr_idx(buf_wr_idx), .buf_wr_overflow(buf_wr_overflow), .buf_wr_idx_rst(buf_wr_idx_rst),
        .buf_rd_en(buf_rd_en), .buf_rd_idx(buf_rd_idx), .buf_rd_data(buf_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pfn(out_pfn), .busy(busy),
        .drain_done(drain_done), .drained_cnt(drained_cnt), .ovf_sticky(ovf_sticky)
`ifdef PFN_DRAIN_DEDUP_EN
        , .dedup_cnt(dedup_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Buffer: 1024 x 32, saturating write index, 1-cycle read latency.
    logic [31:0]   bmem [1024];
    logic [IW-1:0] bidx = '0;
    logic          bovf = 1'b0;
    logic [31:0]   brd = '0;
    logic [31:0]   trk_pfn = '0;
    assign buf_wr_idx      = bidx;
    assign buf_wr_overflow = bovf;
    assign buf_rd_data     = brd;
    always @(posedge clk) begin
        if (buf_wr_idx_rst) bidx <= '0;
        else if (buf_wr_en) begin
            bmem[bidx] <= trk_pfn;
            if (bidx != '1) bidx <= bidx + 1'b1;
        end
        bovf <= buf_wr_en && (bidx == '1);
        if (buf_rd_en) brd <= bmem[buf_rd_idx];
    end

    int checks = 0, errors = 0, cyc = 0;
    int rdy_mode = 0, wr_left = 0, wr_prob = 0, rand_pfn = 0, rand_start = 0;
    logic [31:0] next_pfn = '0;
    logic [31:0] filled [$];
    int emit_n = 0, exp_total = 0, outstanding = 0, rd_next = 0;
    int low_n = 0, last_low = 0, done_n = 0, rst_cnt = 0;
    logic stall = 1'b0;
    logic [31:0] stall_pfn = '0;
    logic exp_ovf = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: every accepted write up to the 1023rd lands in the drainable set and must
    // come out once, in order, before the drain that covers it completes.
    task automatic monitor();
        if (!reset_n) begin
            emit_n = 0; exp_total = 0; outstanding = 0; rd_next = 0;
            stall = 1'b0; exp_ovf = 1'b0; low_n = 0;
            return;
        end
        if (trk_wr_en && trk_wr_ready) begin
            if (filled.size() < 1023) filled.push_back(trk_pfn);
            else exp_ovf = 1'b1;
            wr_left--;
            next_pfn = (rand_pfn != 0) ? $urandom : next_pfn + 1;
        end
        if (!trk_wr_ready) low_n++;
        if (buf_rd_en) begin
            chk("rd_idx", buf_rd_idx, rd_next);
            chk("rd_outstanding_le2", outstanding < 2, 1);
            rd_next++;
        end
        if (stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_pfn", out_pfn, stall_pfn);
        end
        stall = out_valid && !out_ready;
        stall_pfn = out_pfn;
        if (out_valid && out_ready) begin
            if (emit_n < filled.size()) chk("beat_pfn", out_pfn, filled[emit_n]);
            else chk("extra_beat", out_valid, 0);
            emit_n++;
        end
        outstanding += int'(buf_rd_en) - int'(out_valid && out_ready);
        if (buf_wr_idx_rst || drain_done) chk("rst_with_done", buf_wr_idx_rst, drain_done);
        if (buf_wr_idx_rst) rst_cnt++;
        if (drain_done) begin
            chk("done_all_emitted", emit_n, filled.size());
            chk("done_no_outstanding", outstanding, 0);
            exp_total += filled.size();
            filled.delete();
            emit_n = 0; rd_next = 0;
            last_low = low_n; low_n = 0;
            done_n++;
        end
    endtask

    task automatic drive();
        cyc++;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 3 == 0);
            default: out_ready = ($urandom_range(0, 1) == 1);
        endcase
        drain_start = (rand_start != 0) && ($urandom_range(0, 15) == 0);
        trk_wr_en = (wr_left > 0) && (wr_prob == 0 || $urandom_range(0, wr_prob) == 0);
        trk_pfn = next_pfn;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic pulse_start();
        drain_start = 1'b1;
        tick();
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_n;
        int n = 0;
        while (done_n == d0 && n < budget) begin tick(); n++; end
        chk("done_timeout", done_n, d0 + 1);
    endtask

    task automatic write_all(input int budget);
        int n = 0;
        while (wr_left > 0 && n < budget) begin tick(); n++; end
        chk("write_timeout", wr_left, 0);
    endtask

    initial begin
        int c0, c1, d1, n;
        reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        chk("rst_trk_wr_ready", trk_wr_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pfn", out_pfn, 0);
        chk("rst_buf_rd_en", buf_rd_en, 0);
        chk("rst_buf_rd_idx", buf_rd_idx, 0);
        chk("rst_drain_done", drain_done, 0);
        chk("rst_idx_rst", buf_wr_idx_rst, 0);
        chk("rst_drained_cnt", drained_cnt, 0);
        chk("rst_ovf", ovf_sticky, 0);
        pulse_start();
        chk("empty_start_ignored", busy, 0);

        // 1: five writes then a CSR drain
        next_pfn = 32'h10; wr_left = 5; write_all(50);
        c0 = rst_cnt;
        pulse_start(); wait_done(200);
        chk("t1_drained", drained_cnt, 5);
        chk("t1_idx_rst_once", rst_cnt - c0, 1);
        chk("t1_ready_low", last_low, 1);
        chk("t1_idle", busy, 0);

        // 2: back-pressure, plus a drain_start while busy
        rdy_mode = 1; next_pfn = 32'h100; wr_left = 8; write_all(50);
        pulse_start();
        repeat (5) tick();
        pulse_start();
        wait_done(300);
        chk("t2_drained", drained_cnt, 13);
        rdy_mode = 0;

        // 3: tracker writes every cycle while draining
        next_pfn = 32'h200; wr_left = 4; write_all(50);
        wr_left = 6;
        pulse_start(); wait_done(300);
        chk("t3_drained", drained_cnt, 23);
        chk("t3_ready_low", last_low, 1);
        chk("t3_writes_done", wr_left, 0);

        // 4: auto-drain at threshold, then disabled
        drain_thresh = 10'd16; next_pfn = 32'h300; wr_left = 16;
        wait_done(400);
        chk("t4_auto_drained", drained_cnt, 39);
        drain_thresh = '0; d1 = done_n;
        wr_left = 20; write_all(100);
        repeat (20) tick();
        chk("t4_no_auto_busy", busy, 0);
        chk("t4_no_auto_done", done_n, d1);
        pulse_start(); wait_done(300);
        chk("t4_manual_drained", drained_cnt, 59);

        // 5: overflow; overwrite slot is never drained
        next_pfn = 32'h1000; wr_left = 1100; write_all(1500);
        repeat (3) tick();
        chk("t5_ovf_sticky", ovf_sticky, exp_ovf);
        chk("t5_ovf_set", ovf_sticky, 1);
        c0 = rst_cnt; c1 = drained_cnt;
        pulse_start(); wait_done(5000);
        chk("t5_drained_1023", drained_cnt - c1, 1023);
        chk("t5_idx_rst", rst_cnt - c0, 1);

        // 6: reset in the middle of a drain
        next_pfn = 32'h2000; wr_left = 10; write_all(50);
        pulse_start();
        n = 0;
        while (emit_n < 3 && n < 200) begin tick(); n++; end
        chk("t6_reached_beat3", emit_n, 3);
        c0 = rst_cnt;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("t6_busy", busy, 0);
        chk("t6_out_valid", out_valid, 0);
        chk("t6_drained_cnt", drained_cnt, 0);
        chk("t6_ovf_cleared", ovf_sticky, 0);
        chk("t6_trk_ready", trk_wr_ready, 1);
        chk("t6_no_idx_rst", rst_cnt - c0, 0);
        chk("t6_idx_kept", buf_wr_idx, 10);
        pulse_start(); wait_done(300);
        chk("t6_redrained", drained_cnt, 10);

        // 7: random writes, random ready, random CSR pulses
        rdy_mode = 2; rand_pfn = 1; wr_prob = 2; next_pfn = $urandom;
        repeat (3) begin
            wr_left = $urandom_range(5, 60);
            rand_start = 1;
            write_all(800);
            rand_start = 0;
            n = 0;
            while (busy && n < 1000) begin tick(); n++; end
            if (buf_wr_idx != '0) begin pulse_start(); wait_done(1000); end
        end
        chk("t7_drained_total", drained_cnt, exp_total);
        chk("t7_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
